fpadd_result_checker: RTL

- On-chip response checker that sits on the output side of the half-precision adder `fpadd`.
- Expected FP16 results are queued in order from a vector source.
- Each adder result strobe pops one expected value, compares it against the adder's `out`/`overflow` under the team's tolerance rule, and accumulates pass/fail statistics.
- A run-control FSM reports DONE or ERROR once a programmed number of vectors has been checked.

---
 rtl/fpadd_chk_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/fpadd_result_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fpadd_chk_pkg.sv
// Shared constants for the fpadd response checker: FP16 field positions and run-state encoding.
package fpadd_chk_pkg;

  localparam int unsigned EXP_MSB  = 14;
  localparam int unsigned EXP_LSB  = 10;
  localparam int unsigned SIGN_BIT = 15;
  localparam logic [4:0]  EXP_ALL_ONES = 5'h1F;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DONE  = ST_DONE,
    S_ERROR = ST_ERROR
  } state_e;

  // Expected value encodes Inf/NaN, so an adder overflow flag is an acceptable answer.
  function automatic logic exp_is_all_ones(input logic [15:0] v);
    return v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A write while full is accepted only when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpadd_result_checker.sv
// Compares fpadd results against an in-order queue of expected FP16 values and
// reports run statistics plus a DONE/ERROR verdict after n_vectors compares.
module fpadd_result_checker
  import fpadd_chk_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CW      = 16,
  parameter bit          TOL_ULP = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [CW-1:0] n_vectors,
  input  logic          exp_valid,
  input  logic [15:0]   exp_data,
  output logic          exp_ready,
  input  logic          res_valid,
  input  logic [15:0]   res_data,
  input  logic          res_overflow,
  output logic          mismatch,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          underrun,
  output logic [15:0]   first_fail_res,
  output logic [15:0]   first_fail_exp,
  output logic [CW-1:0] first_fail_idx,
  output logic [1:0]    state
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [CW-1:0] pass_d, fail_d, idx_q, idx_d, n_q, n_d, ff_idx_d;
  logic [15:0]   ff_res_d, ff_exp_d;
  logic          underrun_d, mismatch_d;

  logic          fifo_full, fifo_empty;
  logic [15:0]   head;
  logic [15:0]   head_p1;
  logic          compare, hit;

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (exp_valid),
    .pop   (compare),
    .din   (exp_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign exp_ready = !fifo_full;
  assign state     = state_q;

  // Tolerance rule: exact, +1 ulp with 16-bit wrap, or overflow against an Inf/NaN expectation.
  assign head_p1 = 16'(head + 16'd1);
  assign compare = res_valid && !fifo_empty && (state_q == S_RUN);
  assign hit     = (res_data == head)
                || (TOL_ULP && (res_data == head_p1))
                || (res_overflow && exp_is_all_ones(head));

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_cnt;
    fail_d     = fail_cnt;
    underrun_d = underrun;
    ff_res_d   = first_fail_res;
    ff_exp_d   = first_fail_exp;
    ff_idx_d   = first_fail_idx;
    idx_d      = idx_q;
    n_d        = n_q;
    mismatch_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_RUN;
          pass_d     = '0;
          fail_d     = '0;
          underrun_d = 1'b0;
          ff_res_d   = '0;
          ff_exp_d   = '0;
          ff_idx_d   = '0;
          idx_d      = '0;
          n_d        = n_vectors;
        end
      end
      S_RUN: begin
        if (compare) begin
          idx_d = idx_q + CW'(1);
          if (hit) begin
            if (pass_cnt != CNT_MAX) pass_d = pass_cnt + CW'(1);
          end else begin
            mismatch_d = 1'b1;
            if (fail_cnt != CNT_MAX) fail_d = fail_cnt + CW'(1);
            if (fail_cnt == '0) begin
              ff_res_d = res_data;
              ff_exp_d = head;
              ff_idx_d = idx_q;
            end
          end
        end
        if (res_valid && fifo_empty) underrun_d = 1'b1;
        // The verdict uses this cycle's compare outcome as well.
        if ((idx_d == n_q) || start) begin
          state_d = ((fail_d != '0) || underrun_d) ? S_ERROR : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      underrun       <= 1'b0;
      first_fail_res <= '0;
      first_fail_exp <= '0;
      first_fail_idx <= '0;
      idx_q          <= '0;
      n_q            <= '0;
      mismatch       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pass_cnt       <= pass_d;
      fail_cnt       <= fail_d;
      underrun       <= underrun_d;
      first_fail_res <= ff_res_d;
      first_fail_exp <= ff_exp_d;
      first_fail_idx <= ff_idx_d;
      idx_q          <= idx_d;
      n_q            <= n_d;
      mismatch       <= mismatch_d;
    end
  end

endmodule
